sq_finder: RTL and testbench

Sequential squarer: the companion of the square-root finder. It takes a WIDTH-bit root and produces its 2·WIDTH-bit square by accumulating successive odd numbers (1+3+5+…). Structure is a small controller FSM plus a datapath. It sits beside the root finder so a bench or a higher-level block can close the loop sqrt(a)² ≤ a, and it uses the same start-driven controller/datapath style.

---
 rtl/sq_finder_if.sv | 26 ++
 rtl/sq_finder.sv | 104 ++++++++++
 tb/tb_sq_finder.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/sq_finder_if.sv
// ---------------------------------------------------------------------------
// sq_finder_if : request/result bundle for the sequential squarer
// Rev 1.0 : initial release (err member present with SQ_FINDER_ERR_EN)
// ---------------------------------------------------------------------------
`default_nettype none

interface sq_finder_if #(
  parameter int WIDTH = 4
);
  logic                 start;
  logic [WIDTH-1:0]     root;
  logic [2*WIDTH-1:0]   sq;
  logic                 busy;
  logic                 done;
`ifdef SQ_FINDER_ERR_EN
  logic                 err;

  modport master (output start, root, input sq, busy, done, err);
  modport slave  (input start, root, output sq, busy, done, err);
`else
  modport master (output start, root, input sq, busy, done);
  modport slave  (input start, root, output sq, busy, done);
`endif
endinterface

`default_nettype wire

// File: rtl/sq_finder.sv
// ---------------------------------------------------------------------------
// sq_finder : squares a WIDTH-bit root by summing successive odd numbers.
// Optional sticky start-while-busy flag: define SQ_FINDER_ERR_EN.
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module sq_finder #(
  parameter int WIDTH = 4
) (
  input  wire logic   clk,
  input  wire logic   clr,
  sq_finder_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     cnt_q, cnt_d;
  logic [WIDTH:0]       odd_q, odd_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   sq_q, sq_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      odd_q   <= '0;
      acc_q   <= '0;
      sq_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      odd_q   <= odd_d;
      acc_q   <= acc_d;
      sq_q    <= sq_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    odd_d   = odd_q;
    acc_d   = acc_q;
    sq_d    = sq_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_ADD;
          cnt_d   = bus.root;
          acc_d   = '0;
          odd_d   = (WIDTH+1)'(1);
        end
      end
      S_ADD: begin
        if (cnt_q != '0) begin
          acc_d = acc_q + (2*WIDTH)'(odd_q);
          odd_d = odd_q + (WIDTH+1)'(2);
          cnt_d = cnt_q - WIDTH'(1);
        end else begin
          sq_d    = acc_q;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // busy is registered from the next state so it tracks IDLE exactly
    busy_d = (state_d != S_IDLE);
  end

  assign bus.sq   = sq_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

`ifdef SQ_FINDER_ERR_EN
  logic err_q;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      err_q <= 1'b0;
    end else if (bus.start && busy_q) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sq_finder.sv
// ---------------------------------------------------------------------------
// tb_sq_finder : scoreboard bench for sq_finder (expected square + done cycle)
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sq_finder;

  localparam int WIDTH = 4;

  logic clk = 1'b0;
  logic clr;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  typedef struct {
    int sq;
    int when;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  sq_finder_if #(.WIDTH(WIDTH)) bus ();

  sq_finder #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Every done pulse must match the oldest outstanding request
  always @(negedge clk) begin
    if (clr === 1'b1 && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_empty", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sq", 32'(bus.sq), 32'(e.sq));
        chk("latency", 32'(cyc), 32'(e.when));
      end
    end
  end

  task automatic start_op(input int r);
    @(negedge clk);
    bus.root  = 4'(r);
    bus.start = 1'b1;
    sb.push_back('{sq: r * r, when: cyc + 1 + r + 1});
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_rise", 32'(bus.busy), 32'd1);
  endtask

  task automatic finish_op();
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      chk("done_timeout", 32'd0, 32'd1);
    end else begin
      chk("busy_at_done", 32'(bus.busy), 32'd1);
      @(negedge clk);
      chk("done_pulse", 32'(bus.done), 32'd0);
      chk("busy_fall", 32'(bus.busy), 32'd0);
    end
  endtask

  task automatic run_op(input int r);
    start_op(r);
    finish_op();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bus.start = 1'b0;
    bus.root  = '0;
    clr = 1'b1;
    #1 clr = 1'b0;
    #1;
    chk("rst_sq", 32'(bus.sq), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
`ifdef SQ_FINDER_ERR_EN
    chk("rst_err", 32'(bus.err), 32'd0);
`endif
    repeat (2) @(negedge clk);
    clr = 1'b1;

    run_op(0);
    run_op(5);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("sq_hold", 32'(bus.sq), 32'd25);
    end

    for (int r = 0; r < 16; r++) run_op(r);
    chk("sq_max", 32'(bus.sq), 32'd225);

    // start held high: accepts every root+3 = 12 edges
    @(negedge clk);
    base = cyc + 1;
    bus.root  = 4'd9;
    bus.start = 1'b1;
    for (int k = 0; k < 3; k++) sb.push_back('{sq: 81, when: base + 12 * k + 10});
    while (cyc < base + 25) @(negedge clk);
    bus.root = 4'd3;
    @(negedge clk);
    bus.start = 1'b0;
    while (cyc < base + 38) @(negedge clk);
    chk("held_drain", 32'(sb.size()), 32'd0);
    chk("held_sq", 32'(bus.sq), 32'd81);
`ifdef SQ_FINDER_ERR_EN
    chk("held_err", 32'(bus.err), 32'd1);
`endif

    // asynchronous clear in the middle of ADD
    start_op(12);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2 clr = 1'b0;
    sb.delete();
    #1;
    chk("clr_sq", 32'(bus.sq), 32'd0);
    chk("clr_busy", 32'(bus.busy), 32'd0);
    chk("clr_done", 32'(bus.done), 32'd0);
`ifdef SQ_FINDER_ERR_EN
    chk("clr_err", 32'(bus.err), 32'd0);
`endif
    @(negedge clk);
    clr = 1'b1;
    run_op(4);
    chk("after_clr_sq", 32'(bus.sq), 32'd16);

`ifdef SQ_FINDER_ERR_EN
    chk("err_idle", 32'(bus.err), 32'd0);
    start_op(4);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("err_set", 32'(bus.err), 32'd1);
    finish_op();
    repeat (5) @(negedge clk);
    chk("err_sticky", 32'(bus.err), 32'd1);
    chk("err_op_sq", 32'(bus.sq), 32'd16);
    clr = 1'b0;
    #1;
    chk("err_clr", 32'(bus.err), 32'd0);
    @(negedge clk);
    clr = 1'b1;
`endif

    repeat (2) @(negedge clk);
    chk("sb_final", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
